// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// Both sides: a transfer happens on a rising clk edge where valid && ready; payload is held stable while valid is high and ready low.
interface chunked_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, carry held in a register between slices.
// Optional ADDER_SAT_EN: clamp sum to the signed extreme on overflow.
module chunked_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic              clk,
   input  logic              rst,
   chunked_adder_if.slave    bus,
   output logic [1:0]        dbg_state
);
   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int MSB   = WIDTH - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_n;
   logic [WIDTH-1:0]   a_q, b_q, res_q, sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, cout_q, ovf_q;
   logic               in_ready_c, out_valid_c;
   logic [CHUNK-1:0]   a_sl, b_sl;
   logic [CHUNK:0]     slice;
   logic [WIDTH-1:0]   res_n;
   logic               ovf_n;
   logic               last;
   logic [WIDTH-1:0]   final_sum;

   // One slice of the ripple; res_n is the result bank with this slice merged in.
   always_comb begin
      a_sl  = a_q[int'(idx_q)*CHUNK +: CHUNK];
      b_sl  = b_q[int'(idx_q)*CHUNK +: CHUNK];
      slice = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
      res_n = res_q;
      res_n[int'(idx_q)*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      ovf_n = (a_q[MSB] == b_q[MSB]) && (res_n[MSB] != a_q[MSB]);
      last  = (idx_q == IDX_W'(N-1));
   end

`ifdef ADDER_SAT_EN
   always_comb begin
      final_sum = res_n;
      if (ovf_n)
         final_sum = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign final_sum = res_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   always_comb begin
      state_n     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_n = RUN;
         end
         RUN: begin
            if (last) state_n = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               res_q   <= res_n;
               carry_q <= slice[CHUNK];
               if (last) begin
                  idx_q  <= '0;
                  sum_q  <= final_sum;
                  cout_q <= slice[CHUNK];
                  ovf_q  <= ovf_n;
               end else begin
                  idx_q  <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed and random bench for chunked_adder (N=4 instance plus an N=1 instance).
module tb_chunked_adder;
   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   chunked_adder_if #(.WIDTH(W)) bus ();
   chunked_adder_if #(.WIDTH(W)) bus1 ();
   logic [1:0] dbg_state, dbg_state1;

   chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );
   chunked_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg_state1)
   );

   int passed = 0;
   int failed = 0;
   int total  = 0;
   logic [W+1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference from integer arithmetic: {sum, cout, ovf}.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int sa, sb, r;
      logic [W-1:0] s;
      logic co, ov;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = sub ? sa - sb : sa + sb;
      ov = (r > 32767) || (r < -32768);
      s  = sub ? a - b : a + b;
      co = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
`ifdef ADDER_SAT_EN
      if (ov) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return {s, co, ov};
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int k;
      bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
      exp_q.push_back(model(a, b, sub));
      k = 0;
      while (!bus.in_ready && k < 40) begin
         @(posedge clk); #1; k++;
      end
      check("accept_wait", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("out_wait", bus.out_valid, 1);
   endtask

   task automatic pop_check(input string tag);
      logic [W+1:0] e;
      check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_sum"},  bus.sum,  e[W+1:2]);
         check({tag, "_cout"}, bus.cout, e[1]);
         check({tag, "_ovf"},  bus.ovf,  e[0]);
      end
   endtask

   task automatic ack(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_ack_out_valid"}, bus.out_valid, 0);
      check({tag, "_ack_in_ready"},  bus.in_ready,  1);
   endtask

   task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int lat;
      send(a, b, sub);
      wait_out(lat);
      check({tag, "_latency"}, lat, N);
      pop_check(tag);
      ack(tag);
   endtask

   initial begin
      int lat;
      logic [W+1:0] e1;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready",  bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_sum",       bus.sum, 0);
      check("rst_cout",      bus.cout, 0);
      check("rst_ovf",       bus.ovf, 0);
      check("rst_state",     dbg_state, 0);

      op("add_basic",   16'h1234, 16'h0001, 1'b0);
      op("add_ripple",  16'hFFFF, 16'h0001, 1'b0);
      op("add_ovf",     16'h7FFF, 16'h0001, 1'b0);
      op("sub_neg",     16'h0005, 16'h0007, 1'b1);
      op("sub_ovf",     16'h8000, 16'h0001, 1'b1);
      op("sub_zero",    16'h1234, 16'h0000, 1'b1);
      op("sub_minneg",  16'h0000, 16'h8000, 1'b1);

      for (int i = 0; i < 6; i++)
         op("rand", W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

      // Backpressure with a new operand pending.
      send(16'h0100, 16'h0200, 1'b0);
      wait_out(lat);
      bus.a = 16'h0003; bus.b = 16'h0004; bus.sub = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_sum_stable", bus.sum, 16'h0300);
         check("bp_in_ready",   bus.in_ready, 0);
         check("bp_out_valid",  bus.out_valid, 1);
      end
      pop_check("bp_first");
      exp_q.push_back(model(16'h0003, 16'h0004, 1'b0));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_idle_in_ready", bus.in_ready, 1);
      check("bp_idle_state",    dbg_state, 0);
      @(posedge clk); #1;
      check("bp_accept_in_ready", bus.in_ready, 0);
      check("bp_accept_state",    dbg_state, 1);
      bus.in_valid = 1'b0;
      wait_out(lat);
      check("bp_second_latency", lat, N);
      pop_check("bp_second");
      ack("bp_second");

      // Reset in the middle of RUN, at slice 2.
      op("pre_rst", 16'h4321, 16'h1111, 1'b0);
      send(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      check("midrst_in_ready",  bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_sum",       bus.sum, 0);
      check("midrst_cout",      bus.cout, 0);
      check("midrst_ovf",       bus.ovf, 0);
      op("post_rst", 16'h0010, 16'h0020, 1'b0);

      // N=1: a single RUN cycle.
      bus1.a = 16'hABCD; bus1.b = 16'h1234; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
      e1 = model(16'hABCD, 16'h1234, 1'b0);
      check("n1_in_ready", bus1.in_ready, 1);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("n1_latency", lat, 1);
      check("n1_sum",  bus1.sum,  e1[W+1:2]);
      check("n1_cout", bus1.cout, e1[1]);
      check("n1_ovf",  bus1.ovf,  e1[0]);
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      check("n1_ack_in_ready", bus1.in_ready, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
